// File: rtl/if_id_skid_reg_pkg.sv
// Shared defaults and occupancy encoding for the IF/ID skid register.
// Imported by the interface, the slot sub-module and the top level.
package if_id_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF    = 32;
    localparam int CNT_W_DEF   = 16;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        OCC_EMPTY = ST_EMPTY,
        OCC_ONE   = ST_ONE,
        OCC_FULL  = ST_FULL
    } occ_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Valid/ready instruction stream carrying an instruction and its PC+4.
// The producer uses the master modport, the consumer the slave modport.
interface if_id_skid_reg_if
    import if_id_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
);

    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;

    modport master (
        output valid,
        output instr,
        output pc4,
        input  ready
    );

    modport slave (
        input  valid,
        input  instr,
        input  pc4,
        output ready
    );

endinterface

// File: rtl/if_id_skid_reg_slot.sv
// One storage slot: a valid flag plus a payload register.
// Clear beats load; the payload keeps its last value when not loaded.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter int W = INSTR_W_DEF + PC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;

    always_comb begin
        vld_d = vld_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (ld_i) begin
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload needs no reset: consumers only look at it while vld_o is set.
    always_ff @(posedge clk) begin
        if (ld_i && !clr_i) begin
            data_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer and branch flush.
// Optional saturating stall counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
`ifdef IF_ID_STALL_CNT_EN
    ,
    parameter int                 CNT_W     = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    if_id_skid_reg_if.slave   in_if,
    if_id_skid_reg_if.master  out_if,
    input  logic              flush
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam int PL_W = INSTR_W + PC_W;

    occ_e            state_q;
    occ_e            state_d;
    logic            acc;
    logic            drn;
    logic            main_ld;
    logic            main_clr;
    logic            main_from_skid;
    logic            skid_ld;
    logic            skid_clr;
    logic            main_vld;
    logic            skid_vld;
    logic [PL_W-1:0] in_pl;
    logic [PL_W-1:0] main_din;
    logic [PL_W-1:0] main_pl;
    logic [PL_W-1:0] skid_pl;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_if.ready = rst & ~skid_vld;
    assign acc         = in_if.valid & in_if.ready;
    assign drn         = main_vld & out_if.ready;
    assign in_pl       = {in_if.instr, in_if.pc4};
    assign main_din    = main_from_skid ? skid_pl : in_pl;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (acc) begin
                    state_d = OCC_ONE;
                    main_ld = 1'b1;
                end
            end
            OCC_ONE: begin
                if (acc && drn) begin
                    main_ld = 1'b1;
                end else if (acc) begin
                    state_d = OCC_FULL;
                    skid_ld = 1'b1;
                end else if (drn) begin
                    state_d  = OCC_EMPTY;
                    main_clr = 1'b1;
                end
            end
            OCC_FULL: begin
                if (drn) begin
                    state_d        = OCC_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
            end
            default: begin
                state_d  = OCC_EMPTY;
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        // Flush overrides every other event, including a beat accepted this cycle.
        if (flush) begin
            state_d        = OCC_EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
            main_clr       = 1'b1;
            skid_clr       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    if_id_slot #(.W(PL_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr_i (main_clr),
        .ld_i  (main_ld),
        .d_i   (main_din),
        .vld_o (main_vld),
        .q_o   (main_pl)
    );

    if_id_slot #(.W(PL_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   (in_pl),
        .vld_o (skid_vld),
        .q_o   (skid_pl)
    );

    // Decode sees a NOP bubble whenever the main slot is empty.
    assign out_if.valid = main_vld;
    assign out_if.instr = main_vld ? main_pl[PL_W-1:PC_W] : NOP_INSTR;
    assign out_if.pc4   = main_vld ? main_pl[PC_W-1:0]    : '0;

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cnt_d = (main_vld && !out_if.ready) ? sat_inc(cnt_q) : cnt_q;

    // Only reset clears the counter; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule
